// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: opcodes, FSM states, status codes and instruction
// field positions shared by cpu_core and cpu_core_alu.
// Macro CPU_CORE_SHIFT_EN: when defined, SHL/SHR are legal opcodes.
package cpu_core_pkg;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LOAD   = 8'h01;
   localparam logic [7:0] OP_STORE  = 8'h02;
   localparam logic [7:0] OP_LOADLI = 8'h03;
   localparam logic [7:0] OP_LOADHI = 8'h04;
   localparam logic [7:0] OP_JUMPZ  = 8'h05;
   localparam logic [7:0] OP_MOV    = 8'h06;
   localparam logic [7:0] OP_AND    = 8'h07;
   localparam logic [7:0] OP_OR     = 8'h08;
   localparam logic [7:0] OP_XOR    = 8'h09;
   localparam logic [7:0] OP_ADD    = 8'h0A;
   localparam logic [7:0] OP_SUB    = 8'h0B;
   localparam logic [7:0] OP_SHL    = 8'h0C;
   localparam logic [7:0] OP_SHR    = 8'h0D;
   localparam logic [7:0] OP_JUMP   = 8'h0E;
   localparam logic [7:0] OP_HALT   = 8'h0F;

   localparam logic [7:0] ST_RESET = 8'hA0;
   localparam logic [7:0] ST_RUN   = 8'h00;
   localparam logic [7:0] ST_HALT  = 8'hF0;
   localparam logic [7:0] ST_ILL   = 8'hE0;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 24;
   localparam int RA_LSB  = 16;
   localparam int RB_LSB  = 8;
   localparam int RC_LSB  = 0;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      FETCH,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   function automatic logic legal_op(input logic [7:0] op);
      logic ok;
      ok = (op <= OP_HALT);
`ifndef CPU_CORE_SHIFT_EN
      if (op == OP_SHL || op == OP_SHR) ok = 1'b0;
`endif
      return ok;
   endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// cpu_core_alu: combinational ALU for the register-register ops.
// Ports: op (opcode), a/b (operands), result. Shifts need CPU_CORE_SHIFT_EN.
module cpu_core_alu
   import cpu_core_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [7:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

`ifdef CPU_CORE_SHIFT_EN
   localparam int SW = $clog2(DATA_W);

   // only the low log2(DATA_W) bits of b form the shift distance
   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];
`endif

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
`ifdef CPU_CORE_SHIFT_EN
         OP_SHL:  result = a << sh;
         OP_SHR:  result = a >> sh;
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle register-file CPU on one shared sync RAM port.
// Ports: clk, nreset (sync, active-low), addr/wdata/rdata/wren RAM bus,
// status code, halted, retire pulse. Macro CPU_CORE_SHIFT_EN adds SHL/SHR.
module cpu_core
   import cpu_core_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 16,
   parameter int                NREG     = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              nreset,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              wren,
   output logic [7:0]        status,
   output logic              halted,
   output logic              retire
);

   localparam int RW = $clog2(NREG);

   state_t state, state_nx;

   logic [ADDR_W-1:0] pc, pc_nx, pc_inc, pc_rel;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] a, b, alu_y;
   logic [7:0]        op;
   logic [RW-1:0]     ra, rb, rc;
   logic [15:0]       imm;
   logic [RW-1:0]     mem_ra;
   logic              mem_load;
   logic              unused_bits;

   assign op  = rdata[OP_MSB:OP_LSB];
   assign ra  = rdata[RA_LSB +: RW];
   assign rb  = rdata[RB_LSB +: RW];
   assign rc  = rdata[RC_LSB +: RW];
   assign imm = rdata[IMM_MSB:IMM_LSB];

   // high index bits are ignored when NREG < 256
   assign unused_bits = ^rdata;

   assign a = regs[ra];
   assign b = regs[rb];

   assign pc_inc = pc + ADDR_W'(1);
   assign pc_rel = pc + ADDR_W'($signed(imm));

   assign halted = (state == HALT);

   cpu_core_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (op),
      .a      (a),
      .b      (b),
      .result (alu_y)
   );

   always_ff @(posedge clk) begin
      if (!nreset) state <= FETCH;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc_inc;
      unique case (state)
         FETCH: state_nx = EXEC;
         EXEC: begin
            unique case (1'b1)
               op == OP_LOAD || op == OP_STORE:
                  state_nx = MEM;
               op == OP_HALT || !legal_op(op):
                  state_nx = HALT;
               default:
                  state_nx = FETCH;
            endcase
            if (op == OP_JUMP || (op == OP_JUMPZ && a == '0))
               pc_nx = pc_rel;
         end
         MEM:     state_nx = mem_load ? WB : FETCH;
         WB:      state_nx = FETCH;
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         pc       <= RESET_PC;
         addr     <= RESET_PC;
         wdata    <= '0;
         wren     <= 1'b0;
         retire   <= 1'b0;
         status   <= ST_RESET;
         mem_ra   <= '0;
         mem_load <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         unique case (state)
            FETCH: status <= ST_RUN;
            EXEC: begin
               mem_ra   <= ra;
               mem_load <= (op == OP_LOAD);
               unique case (state_nx)
                  MEM: begin
                     addr <= ADDR_W'(imm);
                     if (op == OP_STORE) begin
                        wdata <= a;
                        wren  <= 1'b1;
                     end
                  end
                  HALT: status <= (op == OP_HALT) ? ST_HALT : ST_ILL;
                  default: begin
                     pc     <= pc_nx;
                     addr   <= pc_nx;
                     retire <= 1'b1;
                  end
               endcase
               case (op)
                  OP_LOADLI: regs[ra][15:0]  <= imm;
                  OP_LOADHI: regs[ra][31:16] <= imm;
                  OP_MOV:    regs[rb]        <= a;
                  OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB:
                     regs[rc] <= alu_y;
`ifdef CPU_CORE_SHIFT_EN
                  OP_SHL, OP_SHR:
                     regs[rc] <= alu_y;
`endif
                  default: ;
               endcase
            end
            MEM: begin
               if (!mem_load) begin
                  wren   <= 1'b0;
                  pc     <= pc_inc;
                  addr   <= pc_inc;
                  retire <= 1'b1;
               end
            end
            WB: begin
               regs[mem_ra] <= rdata;
               pc           <= pc_inc;
               addr         <= pc_inc;
               retire       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: bench for cpu_core with a behavioural RAM, a vector
// table, hand sequences and random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_cpu_core;

`ifdef CPU_CORE_SHIFT_EN
   localparam bit SHIFT_ON = 1'b1;
`else
   localparam bit SHIFT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        wren;
   logic [7:0]  status;
   logic        halted;
   logic        retire;

   cpu_core dut (
      .clk    (clk),
      .nreset (nreset),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .wren   (wren),
      .status (status),
      .halted (halted),
      .retire (retire)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM with a bench load port
   logic [31:0] mem [0:65535];
   logic        ld_en = 1'b0;
   logic [15:0] ld_a = '0;
   logic [31:0] ld_d = '0;

   always @(posedge clk) begin
      if (ld_en)     mem[ld_a] <= ld_d;
      else if (wren) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } st_t;

   st_t sq[$];
   int  ret_cnt = 0;

   always @(negedge clk) begin
      if (retire) ret_cnt++;
      if (wren) sq.push_back({addr, wdata});
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enci(input logic [7:0] op,
      input logic [7:0] ra, input logic [15:0] imm);
      return {op, ra, imm};
   endfunction

   function automatic logic [31:0] enr(input logic [7:0] op,
      input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] rc);
      return {op, ra, rb, rc};
   endfunction

   task automatic poke(input logic [15:0] a, input logic [31:0] d);
      ld_en = 1'b1;
      ld_a  = a;
      ld_d  = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      nreset = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic run_to_halt(input int bound, output int cyc);
      cyc = 0;
      while (!halted && cyc < bound) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      chk("halt_reached", {31'b0, halted}, 32'd1);
   endtask

   // ISA-level reference: walks the program word by word
   st_t        mq[$];
   int         m_ret, m_cyc;
   logic [7:0] m_st;

   task automatic model(input logic [31:0] p [16],
                        input logic [31:0] d [16]);
      logic [31:0] r [8];
      logic [31:0] dm [16];
      int pc;
      for (int i = 0; i < 8; i++) r[i] = '0;
      dm = d;
      pc = 0;
      mq.delete();
      m_ret = 0;
      m_cyc = 0;
      m_st  = 8'h55;
      for (int step = 0; step < 64; step++) begin
         logic [31:0] w, x, y;
         logic [7:0]  op;
         logic [15:0] imm;
         int ai, bi, ci, npc;
         if (pc > 15) break;
         w   = p[pc];
         op  = w[31:24];
         ai  = int'(w[18:16]);
         bi  = int'(w[10:8]);
         ci  = int'(w[2:0]);
         imm = w[15:0];
         x   = r[ai];
         y   = r[bi];
         npc = pc + 1;
         if (op == 8'h0F) begin
            m_st = 8'hF0; m_cyc += 2; break;
         end
         if (op > 8'h0F || (!SHIFT_ON && (op == 8'h0C || op == 8'h0D))) begin
            m_st = 8'hE0; m_cyc += 2; break;
         end
         m_ret++;
         m_cyc += 2;
         case (op)
            8'h01: begin r[ai] = dm[imm[3:0]]; m_cyc += 2; end
            8'h02: begin
               dm[imm[3:0]] = x;
               mq.push_back({imm, x});
               m_cyc += 1;
            end
            8'h03: r[ai] = {x[31:16], imm};
            8'h04: r[ai] = {imm, x[15:0]};
            8'h05: if (x == 0) npc = pc + int'($signed(imm));
            8'h06: r[bi] = x;
            8'h07: r[ci] = x & y;
            8'h08: r[ci] = x | y;
            8'h09: r[ci] = x ^ y;
            8'h0A: r[ci] = x + y;
            8'h0B: r[ci] = x - y;
            8'h0C: r[ci] = x << (y % 32);
            8'h0D: r[ci] = x >> (y % 32);
            8'h0E: npc = pc + int'($signed(imm));
            default: ;
         endcase
         pc = npc;
      end
   endtask

   typedef struct packed {
      logic [7:0][31:0] prog;
      logic [15:0]      daddr;
      logic [31:0]      ddata;
      logic [7:0]       nst;
      logic [15:0]      sa;
      logic [31:0]      sd;
      logic [7:0]       st;
      logic [7:0]       ret;
      logic [7:0]       cyc;
   } vec_t;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      vec_t        vecs[$];
      logic [31:0] prog [16];
      logic [31:0] dat [16];
      int          cyc, r0, s0, k;
      st_t         s;

      // reset asserted for 3 cycles in the middle of a STORE
      hold_reset();
      poke(16'h0000, enci(8'h03, 8'd1, 16'h1234));
      poke(16'h0001, enci(8'h04, 8'd1, 16'hABCD));
      poke(16'h0002, enci(8'h02, 8'd1, 16'h0100));
      poke(16'h0003, enci(8'h0F, 8'd0, 16'h0000));
      release_reset();
      k = 0;
      while (!wren && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("store_seen", {31'b0, wren}, 32'd1);
      nreset = 1'b0;
      @(negedge clk);
      chk("rst_wren_drop", {31'b0, wren}, 32'd0);
      chk("rst_addr", {16'b0, addr}, 32'h0);
      chk("rst_status", {24'b0, status}, 32'hA0);
      repeat (2) @(negedge clk);
      chk("rst3_wren", {31'b0, wren}, 32'd0);
      chk("rst3_status", {24'b0, status}, 32'hA0);
      chk("rst3_halted", {31'b0, halted}, 32'd0);
      nreset = 1'b1;
      @(negedge clk);
      chk("run_status", {24'b0, status}, 32'h00);
      chk("first_fetch", {16'b0, addr}, 32'h0);

      // vector table
      v = '0;
      v.prog[0] = enci(8'h03, 8'd1, 16'h1234);
      v.prog[1] = enci(8'h04, 8'd1, 16'hABCD);
      v.prog[2] = enci(8'h02, 8'd1, 16'h0100);
      v.prog[3] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'h0;
      v.nst = 1; v.sa = 16'h0100; v.sd = 32'hABCD1234;
      v.st = 8'hF0; v.ret = 3; v.cyc = 9;
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h01, 8'd2, 16'h0100);
      v.prog[1] = enci(8'h03, 8'd3, 16'h1234);
      v.prog[2] = enr(8'h0A, 8'd2, 8'd3, 8'd4);
      v.prog[3] = enci(8'h02, 8'd4, 16'h0101);
      v.prog[4] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'hABCD1234;
      v.nst = 1; v.sa = 16'h0101; v.sd = 32'hABCD2468;
      v.st = 8'hF0; v.ret = 4; v.cyc = 13;
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h03, 8'd2, 16'h0001);
      v.prog[1] = enr(8'h0B, 8'd1, 8'd2, 8'd3);
      v.prog[2] = enci(8'h02, 8'd3, 16'h0102);
      v.prog[3] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'h0;
      v.nst = 1; v.sa = 16'h0102; v.sd = 32'hFFFFFFFF;
      v.st = 8'hF0; v.ret = 3; v.cyc = 9;
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h03, 8'd1, 16'h0001);
      v.prog[1] = enci(8'h03, 8'd2, 16'd33);
      v.prog[2] = enr(8'h0C, 8'd1, 8'd2, 8'd3);
      v.prog[3] = enci(8'h02, 8'd3, 16'h0103);
      v.prog[4] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'h0;
      if (SHIFT_ON) begin
         v.nst = 1; v.sa = 16'h0103; v.sd = 32'h2;
         v.st = 8'hF0; v.ret = 4; v.cyc = 11;
      end else begin
         v.nst = 0; v.st = 8'hE0; v.ret = 2; v.cyc = 6;
      end
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h03, 8'd1, 16'h0005);
      v.prog[1] = 32'h20000000;
      v.daddr = 16'h0100; v.ddata = 32'h0;
      v.nst = 0; v.st = 8'hE0; v.ret = 1; v.cyc = 4;
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h03, 8'd1, 16'h00F0);
      v.prog[1] = enci(8'h04, 8'd1, 16'h8000);
      v.prog[2] = enr(8'h06, 8'd1, 8'd5, 8'd0);
      v.prog[3] = enci(8'h03, 8'd2, 16'h0FF0);
      v.prog[4] = enr(8'h09, 8'd5, 8'd2, 8'd6);
      v.prog[5] = enci(8'h02, 8'd6, 16'h0104);
      v.prog[6] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'h0;
      v.nst = 1; v.sa = 16'h0104; v.sd = 32'h80000F00;
      v.st = 8'hF0; v.ret = 6; v.cyc = 15;
      vecs.push_back(v);

      v = '0;
      v.prog[0] = enci(8'h03, 8'd1, 16'h0007);
      v.prog[1] = enr(8'h0A, 8'd1, 8'd1, 8'd1);
      v.prog[2] = enci(8'h02, 8'd1, 16'h0105);
      v.prog[3] = enci(8'h0F, 8'd0, 16'h0);
      v.daddr = 16'h0100; v.ddata = 32'h0;
      v.nst = 1; v.sa = 16'h0105; v.sd = 32'h0000000E;
      v.st = 8'hF0; v.ret = 3; v.cyc = 9;
      vecs.push_back(v);

      foreach (vecs[i]) begin
         hold_reset();
         for (int j = 0; j < 8; j++) poke(16'(j), vecs[i].prog[j]);
         poke(vecs[i].daddr, vecs[i].ddata);
         release_reset();
         r0 = ret_cnt;
         s0 = sq.size();
         run_to_halt(100, cyc);
         chk($sformatf("v%0d_status", i), {24'b0, status}, {24'b0, vecs[i].st});
         chk($sformatf("v%0d_cycles", i), cyc, {24'b0, vecs[i].cyc});
         chk($sformatf("v%0d_retire", i), ret_cnt - r0, {24'b0, vecs[i].ret});
         chk($sformatf("v%0d_nstore", i), sq.size() - s0, {24'b0, vecs[i].nst});
         if (vecs[i].nst != 0 && sq.size() > s0) begin
            s = sq[sq.size() - 1];
            chk($sformatf("v%0d_saddr", i), {16'b0, s.a}, {16'b0, vecs[i].sa});
            chk($sformatf("v%0d_sdata", i), s.d, vecs[i].sd);
         end
      end

      // JUMPZ back by 2 from pc 5, taken and not taken
      for (int t = 0; t < 2; t++) begin
         hold_reset();
         poke(16'h0000, (t == 1) ? enci(8'h03, 8'd0, 16'h0001) : 32'h0);
         for (int j = 1; j < 5; j++) poke(16'(j), 32'h0);
         poke(16'h0005, enci(8'h05, 8'd0, 16'hFFFE));
         poke(16'h0006, 32'h0);
         release_reset();
         r0 = ret_cnt;
         repeat (12) @(posedge clk);
         @(negedge clk);
         chk($sformatf("jumpz%0d_addr", t), {16'b0, addr},
             (t == 1) ? 32'h6 : 32'h3);
         @(negedge clk);
         chk($sformatf("jumpz%0d_retire", t), ret_cnt - r0, 32'd6);
      end

      // relative JUMP wrapping through 0xFFFF
      hold_reset();
      poke(16'h0000, enci(8'h0E, 8'd0, 16'hFFFF));
      poke(16'hFFFF, enci(8'h0E, 8'd0, 16'h0001));
      release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("jump_back_addr", {16'b0, addr}, 32'hFFFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("jump_wrap_addr", {16'b0, addr}, 32'h0000);

      // illegal opcode freezes the core until reset
      hold_reset();
      poke(16'h0000, enci(8'h03, 8'd1, 16'h0005));
      poke(16'h0001, 32'h20000000);
      poke(16'hFFFF, 32'h0);
      release_reset();
      r0 = ret_cnt;
      run_to_halt(50, cyc);
      chk("ill_status", {24'b0, status}, 32'hE0);
      repeat (5) @(negedge clk);
      chk("ill_addr_frozen", {16'b0, addr}, 32'h1);
      chk("ill_halted", {31'b0, halted}, 32'd1);
      chk("ill_wren", {31'b0, wren}, 32'd0);
      chk("ill_no_retire", ret_cnt - r0, 32'd1);
      nreset = 1'b0;
      @(negedge clk);
      chk("ill_rst_status", {24'b0, status}, 32'hA0);
      chk("ill_rst_halted", {31'b0, halted}, 32'd0);
      chk("ill_rst_addr", {16'b0, addr}, 32'h0);
      nreset = 1'b1;
      @(negedge clk);
      chk("ill_recover", {24'b0, status}, 32'h00);

      // random programs against the ISA model
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 15; i++) begin
            logic [7:0] ra, rb, rc;
            int kind;
            ra = 8'($urandom_range(0, 7));
            rb = 8'($urandom_range(0, 7));
            rc = 8'($urandom_range(0, 7));
            kind = $urandom_range(0, 11);
            case (kind)
               0: prog[i] = enci(8'h03, ra, 16'($urandom));
               1: prog[i] = enci(8'h04, ra, 16'($urandom));
               2: prog[i] = enr(8'h06, ra, rb, rc);
               3, 4, 5, 6:
                  prog[i] = enr(8'h07 + 8'($urandom_range(0, 4)), ra, rb, rc);
               7: prog[i] = SHIFT_ON ?
                     enr(8'h0C + 8'($urandom_range(0, 1)), ra, rb, rc) :
                     enr(8'h0A, ra, rb, rc);
               8: prog[i] = enci(8'h01, ra, 16'h0200 + 16'($urandom_range(0, 15)));
               9: prog[i] = enci(8'h02, ra, 16'h0200 + 16'($urandom_range(0, 15)));
               10: prog[i] = enci(8'h05, ra, (i == 14) ? 16'h1 : 16'h2);
               default: prog[i] = 32'h0;
            endcase
         end
         prog[15] = enci(8'h0F, 8'd0, 16'h0);
         for (int j = 0; j < 16; j++) dat[j] = $urandom;
         model(prog, dat);
         hold_reset();
         for (int j = 0; j < 16; j++) poke(16'(j), prog[j]);
         for (int j = 0; j < 16; j++) poke(16'h0200 + 16'(j), dat[j]);
         release_reset();
         r0 = ret_cnt;
         s0 = sq.size();
         run_to_halt(400, cyc);
         chk($sformatf("rnd%0d_status", t), {24'b0, status}, {24'b0, m_st});
         chk($sformatf("rnd%0d_cycles", t), cyc, m_cyc);
         chk($sformatf("rnd%0d_retire", t), ret_cnt - r0, m_ret);
         chk($sformatf("rnd%0d_nstore", t), sq.size() - s0, mq.size());
         for (int j = 0; j < mq.size() && s0 + j < sq.size(); j++) begin
            chk($sformatf("rnd%0d_st%0d_addr", t, j),
                {16'b0, sq[s0 + j].a}, {16'b0, mq[j].a});
            chk($sformatf("rnd%0d_st%0d_data", t, j),
                sq[s0 + j].d, mq[j].d);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised successor to the team's first 32-bit accumulator-less CPU. It is a multi-cycle, register-file CPU that fetches 32-bit instructions and loads and stores data over one shared single-port synchronous RAM interface. Compared with the first generation it adds:
- configurable data width, address width and register count;
- a signed relative jump;
- SUB, SHL and SHR;
- HALT and illegal-opcode trapping;
- a per-instruction retire pulse for the bench.

## Interface
- DATA_W, 32: register/data width; must be ≥ 32.
- ADDR_W, 16: RAM word address width.
- NREG, 8: register count, power of two, 2..256.
- RESET_PC, 0: first fetch address.

Ports (reset nreset, synchronous, active-low; clock clk):
- clk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- addr  out  ADDR_W  RAM address.
- wdata  out  DATA_W  RAM write data.
- rdata  in  DATA_W  RAM read data; valid in the cycle after the cycle in which addr was sampled by the RAM.
- wren  out  1  RAM write enable.
- status  out  8  0xA0 reset, 0x00 running, 0xF0 halted by HALT, 0xE0 illegal opcode.
- halted  out  1  high in HALT state.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- Instruction word = rdata[31:0].
  - op = [31:24], ra = [23:16], rb = [15:8], rc = [7:0], imm = [15:0].
  - Register indices use the low log2(NREG) bits.
- Opcodes:
  - 0x00 NOP.
  - 0x01 LOAD: r[ra] ← mem[imm].
  - 0x02 STORE: mem[imm] ← r[ra].
  - 0x03 LOADLI: r[ra][15:0] ← imm; other bits kept.
  - 0x04 LOADHI: r[ra][31:16] ← imm; other bits kept.
  - 0x05 JUMPZ: if r[ra] == 0, pc ← pc + sext(imm); else pc + 1.
  - 0x06 MOV: r[rb] ← r[ra].
  - 0x07 AND, 0x08 OR, 0x09 XOR, 0x0A ADD, 0x0B SUB: r[rc] ← r[ra] op r[rb].
  - 0x0C SHL, 0x0D SHR (logical): r[rc] ← r[ra] shifted by r[rb][log2(DATA_W)-1:0].
  - 0x0E JUMP: pc ← pc + sext(imm).
  - 0x0F HALT.
  - Anything else is illegal.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W. Imm is zero-extended except for jumps. pc arithmetic wraps modulo 2^ADDR_W, so pc + 1 at all-ones gives 0.
- Sources read pre-instruction values, so rc == ra is legal.
- States and transitions:
  - FETCH: RAM samples addr = pc. → EXEC.
  - EXEC: decode rdata.
    - ALU/MOV/LOAD*I/jumps: write result, set pc and addr to the next pc, pulse retire, → FETCH.
    - LOAD: addr ← imm, → MEM.
    - STORE: addr ← imm, wdata ← r[ra], wren ← 1, → MEM.
    - HALT: status F0, → HALT.
    - Illegal: status E0, → HALT.
  - MEM:
    - STORE: wren ← 0, addr ← pc + 1, pc ← pc + 1, retire, → FETCH.
    - LOAD: → WB.
  - WB: r[ra] ← rdata, addr ← pc + 1, pc ← pc + 1, retire, → FETCH.
  - HALT: all outputs frozen, wren 0. Left only by reset.
- Reset, including mid-instruction:
  - pc = addr = RESET_PC; wren = 0; wdata = 0; retire = 0; halted = 0; all registers = 0; status = 0xA0; state FETCH.
  - An in-flight STORE is abandoned: wren drops at the reset edge.
  - status becomes 0x00 on the first clock with nreset high.

## Timing
- Cycles per instruction: 2 for ALU, MOV, LOAD*I, jumps and NOP; 3 for STORE; 4 for LOAD. HALT and illegal opcodes enter HALT after 2 cycles.
- wren is high for exactly one cycle per STORE (the MEM cycle), with addr and wdata stable throughout that cycle.
- addr changes only on the EXEC, MEM and WB edges and at reset.
- retire asserts in the cycle after the completing edge. It never asserts for HALT or illegal opcodes.

## Configuration
- CPU_CORE_SHIFT_EN defined: SHL and SHR are implemented as specified above.
- Undefined: no barrel shifter is built, and 0x0C/0x0D decode as illegal (status 0xE0, halt).

## Structure
- Package cpu_core_pkg holds:
  - opcode constants;
  - state enum (FETCH, EXEC, MEM, WB, HALT);
  - status codes;
  - instruction field bit positions.
- Sub-module cpu_core_alu: combinational. Inputs: op, a, b. Output: result. It owns the AND/OR/XOR/ADD/SUB/SHL/SHR logic, with the shifts under CPU_CORE_SHIFT_EN.

## Test plan
- Reset: nreset low for 3 cycles mid-STORE → addr = 0x0000, wren = 0, status = 0xA0. After release, the first fetch is at addr 0x0000 and status = 0x00.
- LOADLI r1,0x1234; LOADHI r1,0xABCD; STORE r1,0x0100 → wren high exactly 1 cycle with addr = 0x0100 and wdata = 0xABCD1234. STORE spans 3 cycles.
- LOAD r2,0x0100; LOADLI r3,0x1234 (r3 = 0x00001234); ADD r2,r3,r4 → r4 = 0xABCD2468. LOAD takes 4 cycles, with 3 retire pulses over the sequence.
- JUMPZ r0,0xFFFE at pc 5 with r0 = 0 → next fetch addr 3. With r0 = 1 → addr 6. JUMP 0x0001 at pc 0xFFFF → addr 0x0000.
- SUB with r[ra] = 0, r[rb] = 1 → 0xFFFFFFFF. SHL by r[rb] = 33 (DATA_W = 32) shifts by 1. Without CPU_CORE_SHIFT_EN, SHL → status 0xE0.
- Opcode 0x20 → status 0xE0, halted = 1, addr frozen, no retire. HALT (0x0F) → status 0xF0. Reset recovers both.
